// File: rtl/stack_arb_pkg.sv
// Shared definitions for the stack arbiter: request op encoding and id width helper.
package stack_arb_pkg;

    localparam logic OP_PUSH = 1'b0;
    localparam logic OP_POP  = 1'b1;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/stack.sv
// LIFO storage with a registered pop output (one-cycle read latency) and synchronous clear.
module stack #(
    parameter int WIDTH = 18,
    parameter int SIZE  = 4
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out
);

    logic [WIDTH-1:0] mem [2**SIZE];
    logic [SIZE:0]    ptr_q;
    logic [SIZE:0]    ptr_d;
    logic [SIZE-1:0]  wr_addr;
    logic [SIZE-1:0]  rd_addr;
    logic [WIDTH-1:0] data_out_q;

    assign wr_addr  = ptr_q[SIZE-1:0];
    assign rd_addr  = ptr_q[SIZE-1:0] - 1'b1;
    assign data_out = data_out_q;

    always_comb begin
        ptr_d = ptr_q;
        if (srst) begin
            ptr_d = '0;
        end else if (push) begin
            ptr_d = ptr_q + 1'b1;
        end else if (pop) begin
            ptr_d = ptr_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        ptr_q <= ptr_d;
    end

    always_ff @(posedge clk) begin
        if (push && !srst) begin
            mem[wr_addr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (pop && !srst) begin
            data_out_q <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/stack_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first eligible requester after last_winner, wrapping.
module rr_arbiter
    import stack_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int IDW     = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] eligible,
    input  logic [IDW-1:0]     last_winner,
    output logic [NUM_REQ-1:0] winner,
    output logic [IDW-1:0]     winner_idx,
    output logic               any
);

    int             idx;
    logic [IDW-1:0] idx_w;

    always_comb begin
        winner     = '0;
        winner_idx = '0;
        any        = 1'b0;
        idx        = 0;
        idx_w      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = int'(last_winner) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            idx_w = IDW'(idx);
            if (!any && eligible[idx_w]) begin
                any        = 1'b1;
                winner_idx = idx_w;
            end
        end
        if (any) begin
            winner[winner_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/stack_arbiter.sv
// Round-robin front end for a shared stack: guards occupancy, drives stack controls,
// and returns popped words to their requesters two cycles after arbitration.
module stack_arbiter
    import stack_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int STACK_WIDTH = 18,
    parameter int STACK_SIZE  = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            flush,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ-1:0]              req_op,
    input  logic [NUM_REQ*STACK_WIDTH-1:0]  req_data,
    output logic [NUM_REQ-1:0]              gnt,
    output logic                            gnt_err,
    output logic                            rsp_valid,
    output logic [id_width(NUM_REQ)-1:0]    rsp_id,
    output logic [STACK_WIDTH-1:0]          rsp_data,
    output logic [STACK_SIZE:0]             count,
    output logic                            full,
    output logic                            empty,
    output logic                            stk_push,
    output logic                            stk_pop,
    output logic                            stk_reset,
    output logic [STACK_WIDTH-1:0]          stk_din,
    input  logic [STACK_WIDTH-1:0]          stk_dout
);

    localparam int IDW = id_width(NUM_REQ);
    localparam logic [STACK_SIZE:0] DEPTH_C = {1'b1, {STACK_SIZE{1'b0}}};
    localparam logic [IDW-1:0]      LAST_RST = IDW'(NUM_REQ - 1);

    logic [STACK_WIDTH-1:0] req_word [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign req_word[gi] = req_data[gi*STACK_WIDTH +: STACK_WIDTH];
    end

    logic [NUM_REQ-1:0]     gnt_q, gnt_d;
    logic                   gnt_err_q, gnt_err_d;
    logic                   stk_push_q, stk_push_d;
    logic                   stk_pop_q, stk_pop_d;
    logic                   stk_reset_q, stk_reset_d;
    logic [STACK_WIDTH-1:0] stk_din_q, stk_din_d;
    logic [STACK_SIZE:0]    count_q, count_d;
    logic [IDW-1:0]         last_q, last_d;
    logic [IDW-1:0]         pop_id_q, pop_id_d;
    logic                   pend_valid_q, pend_valid_d;
    logic [IDW-1:0]         pend_id_q, pend_id_d;

    logic [NUM_REQ-1:0]     eligible;
    logic [NUM_REQ-1:0]     win_oh;
    logic [IDW-1:0]         win_idx;
    logic                   win_any;
    logic                   win_op;
    logic [STACK_WIDTH-1:0] win_data;

    // A request still held during its own grant cycle must not win again.
    assign eligible = req_valid & ~gnt_q;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .eligible    (eligible),
        .last_winner (last_q),
        .winner      (win_oh),
        .winner_idx  (win_idx),
        .any         (win_any)
    );

    assign win_op   = req_op[win_idx];
    assign win_data = req_word[win_idx];

    assign full  = (count_q == DEPTH_C);
    assign empty = (count_q == '0);

    always_comb begin
        gnt_d        = '0;
        gnt_err_d    = 1'b0;
        stk_push_d   = 1'b0;
        stk_pop_d    = 1'b0;
        stk_reset_d  = flush;
        stk_din_d    = stk_din_q;
        count_d      = count_q;
        last_d       = last_q;
        pop_id_d     = pop_id_q;
        pend_valid_d = stk_pop_q;
        pend_id_d    = pop_id_q;
        if (flush) begin
            count_d      = '0;
            last_d       = LAST_RST;
            pend_valid_d = 1'b0;
        end else if (win_any) begin
            gnt_d  = win_oh;
            last_d = win_idx;
            if (win_op == OP_PUSH) begin
                if (full) begin
                    gnt_err_d = 1'b1;
                end else begin
                    stk_push_d = 1'b1;
                    stk_din_d  = win_data;
                    count_d    = count_q + 1'b1;
                end
            end else begin
                if (empty) begin
                    gnt_err_d = 1'b1;
                end else begin
                    stk_pop_d = 1'b1;
                    pop_id_d  = win_idx;
                    count_d   = count_q - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gnt_q        <= '0;
            gnt_err_q    <= 1'b0;
            stk_push_q   <= 1'b0;
            stk_pop_q    <= 1'b0;
            stk_reset_q  <= 1'b1;
            stk_din_q    <= '0;
            count_q      <= '0;
            last_q       <= LAST_RST;
            pop_id_q     <= '0;
            pend_valid_q <= 1'b0;
            pend_id_q    <= '0;
        end else begin
            gnt_q        <= gnt_d;
            gnt_err_q    <= gnt_err_d;
            stk_push_q   <= stk_push_d;
            stk_pop_q    <= stk_pop_d;
            stk_reset_q  <= stk_reset_d;
            stk_din_q    <= stk_din_d;
            count_q      <= count_d;
            last_q       <= last_d;
            pop_id_q     <= pop_id_d;
            pend_valid_q <= pend_valid_d;
            pend_id_q    <= pend_id_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_err   = gnt_err_q;
    assign stk_push  = stk_push_q;
    assign stk_pop   = stk_pop_q;
    assign stk_reset = stk_reset_q;
    assign stk_din   = stk_din_q;
    assign count     = count_q;
    assign rsp_valid = pend_valid_q;
    assign rsp_id    = pend_id_q;
    // The stack's registered output is only meaningful in the response cycle.
    assign rsp_data  = pend_valid_q ? stk_dout : '0;

endmodule

// File: doc/stack_arbiter.md
# stack_arbiter

Shares one `stack` instance (registered pop output, one-cycle read latency) between NUM_REQ requesters. Round-robin arbitration issues at most one push or pop per cycle and tracks occupancy so the stack never silently wraps. Each request is answered with a grant and an error flag, and each pop also returns a data response. Sits between the core request ports and the stack, driving all of the stack's control inputs.

## Interface
- NUM_REQ, 4: number of requesters (2..8)
- STACK_WIDTH, 18: data word width; must match the stack instance
- STACK_SIZE, 4: stack depth is 2**STACK_SIZE words; must match the stack instance
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- flush  in  1  synchronous clear of occupancy and stack
- req_valid  in  NUM_REQ  request pending, one bit per requester
- req_op  in  NUM_REQ  per-requester op: 0 = push, 1 = pop
- req_data  in  NUM_REQ*STACK_WIDTH  push data, requester i at bits [i*STACK_WIDTH +: STACK_WIDTH]
- gnt  out  NUM_REQ  one-hot, single-cycle grant pulse
- gnt_err  out  1  qualifies gnt: 1 = overflow or underflow, no stack operation performed
- rsp_valid  out  1  pop data valid pulse
- rsp_id  out  $clog2(NUM_REQ)  requester that owns rsp_data
- rsp_data  out  STACK_WIDTH  popped word
- count  out  STACK_SIZE+1  current occupancy, 0..2**STACK_SIZE
- full, empty  out  1 each  count == 2**STACK_SIZE / count == 0
- stk_push, stk_pop, stk_reset  out  1 each  stack controls, registered
- stk_din  out  STACK_WIDTH  stack write data, registered
- stk_dout  in  STACK_WIDTH  stack data_out

## Operation
- Requester handshake: hold req_valid/req_op/req_data stable until gnt[i]=1; drop or change them in the cycle after the grant.
- Eligibility: req_valid[i] high and gnt[i] low in the current cycle. The gnt mask prevents double-granting a request that is still held during the grant cycle.
- Round-robin: search starts at last_winner+1 modulo NUM_REQ; last_winner resets to NUM_REQ-1, so requester 0 has first priority after reset.
- Winner with push and full, or pop and empty: grant with gnt_err=1; stk_push/stk_pop stay 0 and count is unchanged. These count as a win for round-robin.
- Otherwise: push → stk_push=1, stk_din=winner's data, count+1. Pop → stk_pop=1, count−1, and a response is queued for the winner.
- stk_push and stk_pop are never asserted together.
- The pending-response pipeline is one stage (valid + id). It enables rsp_valid in the cycle after stk_pop.
- flush or reset: count←0, pending response dropped, last_winner←NUM_REQ-1, stk_reset=1 for one cycle, no grant that cycle.
- Reset values: gnt=0, gnt_err=0, rsp_valid=0, rsp_id=0, rsp_data=0, count=0, empty=1, full=0, stk_push=0, stk_pop=0, stk_din=0, stk_reset=1. stk_reset stays 1 through the first clock after reset deasserts.

## Timing
- Cycle T: request visible, arbitration is combinational.
- Edge end of T: gnt, gnt_err, stk_* and count registered. Visible in T+1.
- Edge end of T+1: the stack performs the operation. For a pop, stk_dout is valid in T+2.
- T+2: rsp_valid=1, rsp_id=winner, rsp_data=stk_dout (combinational pass-through, stable during T+2 only).
- Throughput: one operation per cycle. Back-to-back pops produce back-to-back responses in grant order.
- count, full and empty reflect all operations granted so far, one cycle ahead of the stack's internal pointer. This is required so that a pop after a push in consecutive cycles is judged correctly.
- flush asserted in T: no grant in T+1; count=0 in T+1; any rsp due in T+1 is suppressed.
- Reset asserted mid-operation: all outputs go to their reset values asynchronously.

## Structure
- Shared package `stack_arb_pkg`: op encoding constants OP_PUSH=1'b0 and OP_POP=1'b1, plus the function for the id width.
- Sub-module `rr_arbiter` (NUM_REQ): inputs eligible mask and last_winner; outputs one-hot winner and encoded index. Purely combinational.
- Top level holds the occupancy counter, output registers and response pipeline. Bench instantiates `stack_arbiter` with a real `stack`.

## Test plan
- Reset, then req 0 pushes 0x00011 → gnt=0001 at T+1, gnt_err=0, count=1, empty=0.
- Push 0x00A, 0x00B, then pop → rsp_valid at T+2 with rsp_data=0x00B, rsp_id correct, count=1.
- All four requesters push simultaneously → grants 0001, 0010, 0100, 1000 on consecutive cycles, count=4. Then requester 2 repeats → next winner is 2.
- 16 pushes, then a 17th → gnt_err=1, count stays 16, full=1. Pop from empty after reset → gnt_err=1, no rsp_valid.
- Push 0x1, then pop in the next cycle → pop is not an error; rsp_data=0x1.
- flush with a pop in flight and count=5 → count=0, stk_reset pulse, no rsp_valid, no grant in T+1.
